// File: rtl/masking_pkg.sv
// masking_pkg
//   Shared definitions for the masked datapath: LFSR feedback mask, default
//   seed, encoder FSM states and a single-step Galois LFSR helper.
package masking_pkg;

    localparam logic [31:0] LFSR_MASK    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

    typedef enum logic [1:0] {
        IDLE,
        GATHER,
        OUT
    } enc_state_t;

    // One Galois right-shift step: shift out the lsb and fold it back in
    // through the feedback mask.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

endpackage

// File: rtl/masking_lfsr.sv
// masking_lfsr
//   32-bit Galois LFSR that advances WIDTH steps per enabled cycle and
//   presents the low WIDTH bits of the advanced state as fresh randomness.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (state <= LFSR_SEED)
//   en         advance the state this cycle
//   seed_load  load state from seed this cycle (wins over en)
//   seed       seed value; zero is replaced by LFSR_SEED
//   rnd        low WIDTH bits of the current state advanced WIDTH steps
module masking_lfsr
    import masking_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] LFSR_SEED = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             seed_load,
    input  logic [31:0]      seed,
    output logic [WIDTH-1:0] rnd
);

    logic [31:0] state;
    logic [31:0] stepped;

    // WIDTH unrolled steps; rnd is always derived from the pre-load state so
    // a seed load on the same edge does not change the word consumed now.
    always_comb begin
        stepped = state;
        for (int i = 0; i < WIDTH; i++) begin
            stepped = lfsr_step(stepped);
        end
    end

    assign rnd = stepped[WIDTH-1:0];

    // An all-zero state would lock the LFSR, so a zero seed maps to LFSR_SEED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LFSR_SEED;
        end else if (seed_load) begin
            state <= (seed == 32'd0) ? LFSR_SEED : seed;
        end else if (en) begin
            state <= stepped;
        end
    end

endmodule

// File: rtl/masked_share_encoder.sv
// masked_share_encoder
//   Splits a WIDTH-bit secret into NUM_SHARES Boolean shares whose XOR is the
//   secret. Shares 0..NUM_SHARES-2 are raw LFSR words; the last share is the
//   secret XOR all of them.
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    secret offered
//   in_ready    encoder can accept a secret (IDLE only)
//   in_data     unmasked secret
//   seed_load   reload the LFSR from seed this cycle (any state)
//   seed        LFSR seed value
//   out_valid   shares_out valid
//   out_ready   consumer accepts shares
//   shares_out  share j at bits [j*WIDTH +: WIDTH]
module masked_share_encoder
    import masking_pkg::*;
#(
    parameter int          WIDTH      = 8,
    parameter int          NUM_SHARES = 5,
    parameter logic [31:0] LFSR_SEED  = DEFAULT_SEED
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        seed_load,
    input  logic [31:0]                 seed,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_SHARES*WIDTH-1:0] shares_out
);

    localparam int                CNT_W    = $clog2(NUM_SHARES);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_SHARES - 2);

    enc_state_t       state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rnd;
    logic             lfsr_en;

    // Randomness is only consumed in GATHER, so each accepted secret draws a
    // deterministic run of words from the LFSR.
    assign lfsr_en = (state == GATHER);

    masking_lfsr #(
        .WIDTH     (WIDTH),
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (lfsr_en),
        .seed_load (seed_load),
        .seed      (seed),
        .rnd       (rnd)
    );

    // Handshake flags are decoded from the registered state; in_ready stays
    // low while reset is held.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == OUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            shares_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= in_data;
                        cnt   <= '0;
                        state <= GATHER;
                    end
                end
                GATHER: begin
                    for (int j = 0; j < NUM_SHARES - 1; j++) begin
                        if (cnt == CNT_W'(j)) begin
                            shares_out[j*WIDTH +: WIDTH] <= rnd;
                        end
                    end
                    acc <= acc ^ rnd;
                    cnt <= cnt + CNT_W'(1);
                    // acc ^ rnd here already folds in every random share.
                    if (cnt == LAST_CNT) begin
                        shares_out[(NUM_SHARES-1)*WIDTH +: WIDTH] <= acc ^ rnd;
                        state <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_masked_share_encoder.sv
module tb_masked_share_encoder;

    localparam logic [31:0] DEF_SEED = 32'hACE1_2468;
    localparam logic [31:0] MASK     = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        seed_load = 1'b0;
    logic [31:0] seed = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [39:0] shares_out;

    // NUM_SHARES=2 instance
    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [7:0]  in_data2 = 8'h00;
    logic        out_valid2;
    logic        out_ready2 = 1'b0;
    logic [15:0] shares_out2;

    int total = 0;
    int bad   = 0;
    logic [31:0] m_state;
    int in_hs = 0;
    int out_hs = 0;

    always #5 clk = ~clk;

    masked_share_encoder #(.WIDTH(8), .NUM_SHARES(5), .LFSR_SEED(DEF_SEED)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .seed_load(seed_load), .seed(seed),
        .out_valid(out_valid), .out_ready(out_ready), .shares_out(shares_out)
    );

    masked_share_encoder #(.WIDTH(8), .NUM_SHARES(2), .LFSR_SEED(DEF_SEED)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .seed_load(1'b0), .seed(32'h0),
        .out_valid(out_valid2), .out_ready(out_ready2), .shares_out(shares_out2)
    );

    always @(posedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready)   in_hs++;
            if (out_valid && out_ready) out_hs++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_step8(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < 8; i++) begin
            if (r[0]) r = (r >> 1) ^ MASK;
            else      r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] xor5(input logic [39:0] v);
        return v[7:0] ^ v[15:8] ^ v[23:16] ^ v[31:24] ^ v[39:32];
    endfunction

    task automatic load_seed(input logic [31:0] v);
        seed_load = 1'b1;
        seed      = v;
        @(posedge clk); #1;
        seed_load = 1'b0;
        m_state   = (v == 32'd0) ? DEF_SEED : v;
    endtask

    // One full transfer: accept, wait for out_valid, hold for `stall` cycles
    // with ignored in_valid pulses, then complete the output handshake.
    task automatic encode(input logic [7:0] secret, input int stall, output logic [39:0] got);
        logic [39:0] exp;
        logic [7:0]  x;
        int n;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk("in_ready_idle", in_ready, 1);
        x = secret;
        for (int k = 0; k < 4; k++) begin
            m_state = m_step8(m_state);
            exp[k*8 +: 8] = m_state[7:0];
            x ^= m_state[7:0];
        end
        exp[39:32] = x;

        in_valid  = 1'b1;
        in_data   = secret;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("in_ready_gather", in_ready, 0);
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("latency", n, 4);
        chk("shares", shares_out, exp);
        chk("recombine", xor5(shares_out), secret);

        for (int s = 0; s < stall; s++) begin
            in_valid = s[0];
            in_data  = ~secret;
            @(posedge clk); #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_stable", shares_out, exp);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_in_ready", in_ready, 1);
        chk("post_out_valid", out_valid, 0);
        chk("retention", shares_out, exp);
        got = shares_out;
    endtask

    typedef struct {
        logic        do_seed;
        logic [31:0] seed_v;
        logic [7:0]  secret;
        int          stall;
        logic        chk_s0;
        logic [7:0]  exp_s0;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [39:0] g, g1, g2, g_reset;
        int n;
        int in0, out0;

        // first rnd from DEF_SEED after 8 Galois steps: 0x78B2E125 -> 0x25
        vecs[0] = '{1'b0, 32'h0,          8'hA5, 0,  1'b1, 8'h25};
        vecs[1] = '{1'b1, 32'h0,          8'hC3, 1,  1'b1, 8'h25};
        vecs[2] = '{1'b0, 32'h0,          8'hFF, 10, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 32'hDEAD_BEEF,  8'h00, 2,  1'b0, 8'h00};
        vecs[4] = '{1'b0, 32'h0,          8'h81, 3,  1'b0, 8'h00};

        m_state = DEF_SEED;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_shares", shares_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].do_seed) load_seed(vecs[i].seed_v);
            encode(vecs[i].secret, vecs[i].stall, g);
            if (i == 0) g_reset = g;
            if (vecs[i].chk_s0) chk("vec_share0", g[7:0], vecs[i].exp_s0);
        end

        // same seed twice -> identical shares; zero seed -> reset sequence
        load_seed(32'h1234_5678);
        encode(8'h3C, 1, g1);
        load_seed(32'h1234_5678);
        encode(8'h3C, 0, g2);
        chk("seed_repeat", g2, g1);
        load_seed(32'h0);
        encode(8'hA5, 0, g);
        chk("seed_zero", g, g_reset);

        // reset during the second GATHER cycle
        in_valid = 1'b1;
        in_data  = 8'h77;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_shares", shares_out, 0);
        #2;
        rst_n   = 1'b1;
        m_state = DEF_SEED;
        @(posedge clk); #1;
        encode(8'h00, 0, g);
        chk("midrst_share0", g[7:0], 8'h25);
        chk("midrst_xor", xor5(g), 8'h00);
        chk("midrst_seq", g, {8'h00 ^ g_reset[39:32] ^ 8'hA5, g_reset[31:0]});

        // random secrets with random stalls
        in0  = in_hs;
        out0 = out_hs;
        for (int i = 0; i < 1000; i++) begin
            encode(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)), g);
        end
        chk("in_count", in_hs - in0, 1000);
        chk("out_count", out_hs - out0, 1000);

        // NUM_SHARES=2 instance: one GATHER cycle, share0 = first rnd
        in_valid2  = 1'b1;
        in_data2   = 8'h5A;
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        n = 0;
        while (!out_valid2 && n < 20) begin @(posedge clk); #1; n++; end
        chk("ns2_latency", n, 1);
        chk("ns2_recombine", shares_out2[15:8], 8'h5A ^ shares_out2[7:0]);
        chk("ns2_shares", shares_out2, 16'h7F25);
        @(posedge clk); #1;
        out_ready2 = 1'b0;
        chk("ns2_in_ready", in_ready2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/masked_share_encoder.md
Name: masked_share_encoder

Overview:
- Splits an unmasked WIDTH-bit secret into NUM_SHARES Boolean shares whose XOR equals the secret.
- Supplies the share inputs of the HPC3 masked multiplier and other gadgets in the masked datapath; it is the masking end of the share interface.
- Fresh randomness comes from an internal seedable 32-bit Galois LFSR.
- Valid/ready handshake on both input and output.

Parameters:
WIDTH, 8, bit width of the secret and of each share
NUM_SHARES, 5, number of output shares (legal range >= 2)
LFSR_SEED, 32'hACE1_2468, LFSR value after reset and the substitute value when a zero seed is loaded

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  secret offered
in_ready  output  1  encoder can accept a secret
in_data  input  WIDTH  unmasked secret
seed_load  input  1  load LFSR from seed this cycle
seed  input  32  LFSR seed value
out_valid  output  1  shares valid
out_ready  input  1  consumer accepts shares
shares_out  output  NUM_SHARES*WIDTH  share j occupies bits [j*WIDTH +: WIDTH]

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, LFSR=LFSR_SEED.
  - shares_out=0, out_valid=0, internal accumulator and counter cleared.
  - in_ready=1 only once rst_n=1, since in_ready is decoded from state.
- LFSR step, Galois right-shift with mask 32'h8020_0003:
  - lsb=s[0]; s=s>>1; if lsb, s^=mask.
  - Each advancing cycle applies WIDTH steps (unrolled). The random word rnd is state[WIDTH-1:0] after those steps.
  - The LFSR advances only in GATHER, which makes the sequence deterministic per accepted secret.
- seed_load (honoured in any state):
  - On the next edge, LFSR = (seed==0 ? LFSR_SEED : seed).
  - Takes priority over stepping on that edge. The rnd used that cycle is taken from the pre-load state advanced WIDTH steps.
  - The FSM is not disturbed.
- FSM:
  - IDLE:
    - in_ready=1, out_valid=0.
    - On in_valid: acc<=in_data, cnt<=0, go to GATHER.
  - GATHER (exactly NUM_SHARES-1 cycles):
    - in_ready=0.
    - Each cycle: share[cnt]<=rnd; acc<=acc^rnd; cnt<=cnt+1.
    - On the cycle with cnt==NUM_SHARES-2: also share[NUM_SHARES-1]<=acc^rnd, then go to OUT.
  - OUT:
    - out_valid=1, shares_out held stable, in_ready=0.
    - On out_ready: go to IDLE. in_ready returns the next cycle, so there is no back-to-back acceptance.
- Latency: input accepted on edge E0 -> out_valid=1 after edge E(NUM_SHARES-1); 4 cycles for the defaults.
- Invariant: XOR of all shares == accepted secret. Shares 0..NUM_SHARES-2 are raw LFSR words.
- Retention: shares_out keeps its last value after the output handshake until it is overwritten in GATHER. It is zero only after reset.
- in_valid outside IDLE is ignored. The source must hold in_data until the in handshake completes.
- Reset mid-GATHER or mid-OUT: immediate return to reset state; the partial encoding is discarded and out_valid is never raised for it.
- cnt width: $clog2(NUM_SHARES). acc width: WIDTH. All arithmetic is XOR; no carries.

Decomposition:
- Shared package masking_pkg:
  - LFSR_MASK = 32'h8020_0003
  - DEFAULT_SEED
  - state enum {IDLE, GATHER, OUT}
- One sub-module: masking_lfsr.
  - 32-bit state, WIDTH steps per enable, seed load with zero substitution.
  - Outputs rnd.
  - Reusable later as the r/p randomness source for the HPC3 gadget.

Test Plan:
- Reset, then secret 0xA5 with out_ready=1 -> out_valid rises exactly 4 cycles after acceptance; XOR of the 5 shares == 0xA5; shares 0..3 match the software LFSR model seeded with 32'hACE1_2468.
- Load seed 32'h1234_5678, encode 0x3C; reload the same seed, encode 0x3C -> identical shares_out both times. Load seed 0 -> same shares as after reset.
- Encode 0xFF with out_ready=0 for 10 cycles -> shares_out stable, out_valid=1, in_ready=0 throughout; in_valid pulses ignored; in_ready=1 the cycle after out_ready=1.
- Assert rst_n=0 during the 2nd GATHER cycle -> out_valid=0 and shares_out=0 immediately; next secret 0x00 -> shares equal the post-reset sequence and XOR to 0x00.
- 1000 random secrets with random out_ready stalls -> every transfer XOR-recombines correctly; no lost or duplicated transfers.
- Rebuild with NUM_SHARES=2 and secret 0x5A -> GATHER lasts 1 cycle; shares_out[15:8] == 0x5A ^ shares_out[7:0].
